threshold_adjust_pipe: RTL

Multi-lane, pipelined generalisation of the single-lane threshold adjuster. Each lane compares its input against a runtime threshold. Inputs strictly above the threshold have SUB subtracted; all others have ADD added. Sits in the datapath between a valid/ready producer and consumer, with full backpressure, fixed 2-cycle latency, and per-lane counters of above-threshold samples.

---
 rtl/threshold_adjust_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/threshold_adjust_pipe.sv
// threshold_adjust_pipe: multi-lane 2-stage threshold add/sub datapath.
// Define THRESH_ADJ_SAT_EN to clamp results instead of wrapping them.
module threshold_adjust_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]          cfg_thresh,
  input  logic [WIDTH-1:0]          cfg_sub,
  input  logic [WIDTH-1:0]          cfg_add,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  input  logic                      cnt_clr,
  output logic [CHANNELS*CNT_W-1:0] hit_cnt
);

  typedef logic [WIDTH-1:0] word_t;

  typedef struct packed {
    logic [CHANNELS-1:0]  above;
    word_t [CHANNELS-1:0] lane;
    word_t                sub;
    word_t                add;
  } s1_t;

  s1_t                            s1_q;
  logic                           s1_valid;
  logic                           s2_valid;
  logic                           s1_adv;
  logic                           s2_adv;
  logic                           accept;
  logic [CHANNELS-1:0]            above;
  word_t [CHANNELS-1:0]           lane_in;
  word_t [CHANNELS-1:0]           res;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;

  assign s2_adv    = !s2_valid | out_ready;
  assign s1_adv    = !s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid & s1_adv;
  assign lane_in   = in_data;
  assign out_valid = s2_valid;
  assign hit_cnt   = cnt_q;

  always_comb begin
    above = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      above[i] = lane_in[i] > cfg_thresh;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
`ifdef THRESH_ADJ_SAT_EN
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    assign sum = {1'b0, s1_q.lane[i]} + {1'b0, s1_q.add};
    assign dif = {1'b0, s1_q.lane[i]} - {1'b0, s1_q.sub};

    // Carry out of the add clamps high; borrow out of the subtract clamps low.
    assign res[i] = s1_q.above[i]
                  ? (dif[WIDTH] ? '0 : dif[WIDTH-1:0])
                  : (sum[WIDTH] ? '1 : sum[WIDTH-1:0]);
`else
    assign res[i] = s1_q.above[i]
                  ? s1_q.lane[i] - s1_q.sub
                  : s1_q.lane[i] + s1_q.add;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // Config is captured with the data so later cfg edits cannot reach it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_q.above <= above;
      s1_q.lane  <= lane_in;
      s1_q.sub   <= cfg_sub;
      s1_q.add   <= cfg_add;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n || cnt_clr) begin
        cnt_q[i] <= '0;
      end else if (accept && above[i] && cnt_q[i] != '1) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

endmodule
